tone_poly_sequencer: RTL
========================

TONE_POLY_SEQUENCER -- requirements
Module: tone_poly_sequencer

Interface
REQ-001 SHALL have parameter CH, default 4: number of independent tone channels (1..8).
REQ-002 SHALL have parameter BW, default 24: bit width of the period divider and tone counters.
REQ-003 SHALL have parameter DUR_BW, default 8: bit width of the note duration, in tempo ticks.
REQ-004 SHALL have parameter TICK_DIV, default 24'd2400000: clock cycles per tempo tick (~0.25 s); legal range >= 2.
REQ-005 SHALL have port clk_i  input  1: single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_i  input  1: reset; synchronous, active-high.
REQ-007 SHALL have port note_valid_i  input  1: note load request.
REQ-008 SHALL have port note_ready_o  output  1: load accepted when note_valid_i & note_ready_o.
REQ-009 SHALL have port note_ch_i  input  $clog2(CH) (min 1): target channel of the load.
REQ-010 SHALL have port note_div_i  input  BW: tone period in clk cycles; values 0 and 1 mean rest.
REQ-011 SHALL have port note_dur_i  input  DUR_BW: note length in tempo ticks.
REQ-012 SHALL have port abort_i  input  CH: per-channel stop request.
REQ-013 SHALL have port tone_o  output  CH: per-channel square wave.
REQ-014 SHALL have port busy_o  output  CH: channel in PLAY state.
REQ-015 SHALL have port mix_o  output  1: sigma-delta mix of all channels.
REQ-016 SHALL have port tick_o  output  1: one-cycle tempo tick pulse.

Function
REQ-017 Prescaler SHALL count 0..TICK_DIV-1 and wrap; tick_o SHALL be 1 for exactly the cycle in which the count equals TICK_DIV-1.
REQ-018 Each channel SHALL have two states, IDLE and PLAY, and hold registers div (BW), dur (DUR_BW) and phase counter cnt (BW).
REQ-019 note_ready_o SHALL be combinational: 1 iff note_ch_i < CH, channel note_ch_i is IDLE, and abort_i[note_ch_i] = 0.
REQ-020 On acceptance with note_dur_i != 0: the channel SHALL latch div and dur, clear cnt, enter PLAY at the next edge; busy_o is set in the following cycle.
REQ-021 On acceptance with note_dur_i = 0: the channel SHALL stay IDLE (handshake completes, no-op).
REQ-022 In PLAY with div >= 2: cnt SHALL step 0..div-1 and wrap; tone_o = 1 iff cnt < div>>1 (first high cycle is the cycle after acceptance; odd div gives low-biased duty).
REQ-023 In PLAY with div < 2 (rest): tone_o SHALL be 0 and cnt SHALL stay 0, while dur still counts.
REQ-024 In PLAY, each tick_o SHALL decrement dur; the tick that takes dur from 1 to 0 SHALL move the channel to IDLE at that edge (a note of dur N ends on the N-th tick after acceptance).
REQ-025 A tick in the same cycle as acceptance SHALL NOT decrement the newly loaded dur.
REQ-026 abort_i[c] = 1 SHALL force channel c to IDLE at the next edge with cnt cleared; abort outranks tick and load.
REQ-027 In IDLE: tone_o = 0, busy_o = 0, cnt = 0.
REQ-028 Mixer: accumulator acc of width $clog2(CH)+1; each cycle s = acc + popcount(tone_o); if s >= CH then mix_o <= 1 and acc <= s - CH, else mix_o <= 0 and acc <= s.
REQ-029 Mixer SHALL never overflow: acc < CH always holds.
REQ-030 Channels SHALL be fully independent; loads to different channels in consecutive cycles SHALL all be accepted.

Reset
REQ-031 With rst_i = 1 at an edge: all channels IDLE; div, dur, cnt, acc and prescaler = 0; tone_o, busy_o, mix_o, tick_o = 0.
REQ-032 During rst_i = 1, note_ready_o SHALL be 0 and no load SHALL be accepted.
REQ-033 Reset mid-note SHALL silence the channel at the next edge, with no partial period.

Verification (TICK_DIV = 10, CH = 4, BW = 8, DUR_BW = 4)
REQ-034 Load ch0 div = 8 dur = 2 -> busy_o[0] rises next cycle; tone_o[0] is 4 cycles high / 4 low; busy_o[0] falls on the 2nd tick_o after acceptance.
REQ-035 Load ch1 div = 0 dur = 1 -> busy_o[1] = 1 until the next tick with tone_o[1] = 0 throughout; a reload of ch1 while busy sees note_ready_o = 0.
REQ-036 Load ch2 dur = 3 in the cycle tick_o = 1 -> that tick is ignored; the channel ends on the 3rd later tick.
REQ-037 All 4 channels at div = 2 in phase -> mix_o = 1 on the cycles following all-high cycles, 0 otherwise; acc never reaches 4.
REQ-038 abort_i[3] together with note_valid_i for ch3 -> note_ready_o = 0 and ch3 stays IDLE; abort of a playing ch0 -> tone_o[0] = 0 at the next edge.
REQ-039 rst_i pulsed while 3 channels play -> all outputs 0 at the next edge; prescaler restarts so tick_o occurs 10 cycles after rst_i is released.

Source files
------------

// File: rtl/tone_poly_sequencer.sv
// tone_poly_sequencer: CH independent square-wave tone channels. Each channel
// is loaded with a period divider and a note length in tempo ticks. A shared
// prescaler makes the tempo tick, and a first-order sigma-delta mixer folds
// every channel into one bit.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   note_valid_i/ready  note load handshake; note_ch_i selects the channel
//   note_div_i          tone period in clk cycles (0/1 = rest)
//   note_dur_i          note length in tempo ticks (0 = no-op load)
//   abort_i[CH]         per-channel stop, outranks tick and load
//   tone_o[CH]          per-channel square wave
//   busy_o[CH]          channel is playing
//   mix_o               sigma-delta mix of all tone_o bits
//   tick_o              one-cycle tempo tick

// One tone channel: IDLE/PLAY state, period divider, duration and phase counter.
module tone_channel #(
    parameter int BW     = 24,
    parameter int DUR_BW = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              abort_i,
    input  logic              tick_i,
    input  logic [BW-1:0]     div_i,
    input  logic [DUR_BW-1:0] dur_i,
    output logic              tone_o,
    output logic              busy_o
);
    typedef enum logic {IDLE, PLAY} state_t;

    state_t            state_q, state_d;
    logic [BW-1:0]     div_q, div_d, cnt_q, cnt_d;
    logic [DUR_BW-1:0] dur_q, dur_d;
    logic              rest;

    assign rest = div_q < BW'(2);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            div_q   <= '0;
            dur_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            dur_q   <= dur_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        dur_d   = dur_q;
        cnt_d   = cnt_q;
        tone_o  = 1'b0;
        busy_o  = (state_q == PLAY);
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // A tick in the load cycle is ignored: IDLE never decrements.
                if (load_i && dur_i != '0) begin
                    state_d = PLAY;
                    div_d   = div_i;
                    dur_d   = dur_i;
                end
            end
            PLAY: begin
                // Odd periods round the high half down (low-biased duty).
                tone_o = !rest && (cnt_q < (div_q >> 1));
                if (rest || cnt_q == div_q - BW'(1))
                    cnt_d = '0;
                else
                    cnt_d = cnt_q + BW'(1);
                if (tick_i) begin
                    dur_d = dur_q - DUR_BW'(1);
                    if (dur_q == DUR_BW'(1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end
endmodule

module tone_poly_sequencer #(
    parameter int          CH       = 4,
    parameter int          BW       = 24,
    parameter int          DUR_BW   = 8,
    parameter int unsigned TICK_DIV = 24'd2400000,
    localparam int         CHW      = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              note_valid_i,
    output logic              note_ready_o,
    input  logic [CHW-1:0]    note_ch_i,
    input  logic [BW-1:0]     note_div_i,
    input  logic [DUR_BW-1:0] note_dur_i,
    input  logic [CH-1:0]     abort_i,
    output logic [CH-1:0]     tone_o,
    output logic [CH-1:0]     busy_o,
    output logic              mix_o,
    output logic              tick_o
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int AW = $clog2(CH) + 1;
    // Sum is acc (< CH) plus popcount (<= CH): one extra bit covers 2*CH-1.
    localparam int SW = AW + 1;

    logic [PW-1:0] pre_q;
    logic [CH-1:0] load;
    logic [AW-1:0] acc_q;
    logic [SW-1:0] sum;

    // Tempo prescaler
    assign tick_o = (pre_q == PW'(TICK_DIV - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || tick_o) pre_q <= '0;
        else                 pre_q <= pre_q + PW'(1);
    end

    // Ready is decoded per channel so an out-of-range note_ch_i simply
    // matches nothing instead of indexing past the vector.
    always_comb begin
        note_ready_o = 1'b0;
        for (int c = 0; c < CH; c++)
            if (note_ch_i == CHW'(c) && !busy_o[c] && !abort_i[c] && !rst_i)
                note_ready_o = 1'b1;
    end

    always_comb begin
        load = '0;
        for (int c = 0; c < CH; c++)
            load[c] = note_valid_i && note_ready_o && (note_ch_i == CHW'(c));
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        tone_channel #(.BW(BW), .DUR_BW(DUR_BW)) u_ch (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .load_i  (load[c]),
            .abort_i (abort_i[c]),
            .tick_i  (tick_o),
            .div_i   (note_div_i),
            .dur_i   (note_dur_i),
            .tone_o  (tone_o[c]),
            .busy_o  (busy_o[c])
        );
    end

    // Sigma-delta mixer: emit a 1 each time CH units of tone have accumulated.
    always_comb begin
        sum = SW'(acc_q);
        for (int c = 0; c < CH; c++)
            sum = sum + SW'(tone_o[c]);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
            mix_o <= 1'b0;
        end else if (sum >= SW'(CH)) begin
            acc_q <= AW'(sum - SW'(CH));
            mix_o <= 1'b1;
        end else begin
            acc_q <= AW'(sum);
            mix_o <= 1'b0;
        end
    end
endmodule
